// File: rtl/subsample_420_8x8.sv
// ---------------------------------------------------------------------------
// subsample_420_8x8
// Encoder-side 4:2:0 chroma subsampler for the JPEG block pipeline. It sits
// between colour conversion and the forward DCT.
//
// Chroma (Cb/Cr) arrives as four full-resolution 8x8 quadrants of a 16x16 MCU
// in the order TL, TR, BL, BR. Each 2x2 pixel group is averaged to one sample.
// The four resulting 4x4 tiles are packed into one 8x8 output block.
// Y blocks pass straight through with the same one-cycle latency.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   valid_in   input block valid
//   ready_in   input accepted when valid_in && ready_in
//   ch_in      channel tag (0=Y, 1=Cb, 2=Cr, other=invalid)
//   block_in   signed 8-bit pixels, [row][col], [0][0] is top-left
//   valid_out  output block valid
//   ready_out  downstream accepts when valid_out && ready_out
//   ch_out     channel tag of the output block
//   block_out  registered output block
//   quad_cnt   index of the next expected chroma quadrant (0..3)
//   err        one-cycle pulse: chroma group broken, or invalid channel tag
// ---------------------------------------------------------------------------
module subsample_420_8x8 #(
    parameter int CHW   = 2,
    parameter bit ROUND = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [CHW-1:0]        ch_in,
    input  logic [7:0][7:0][7:0]  block_in,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [CHW-1:0]        ch_out,
    output logic [7:0][7:0][7:0]  block_out,
    output logic [1:0]            quad_cnt,
    output logic                  err
);

    logic                 r_valid;
    logic [CHW-1:0]       r_ch;
    logic [7:0][7:0][7:0] r_block;
    logic [1:0]           r_quad;
    logic                 r_err;
    logic [CHW-1:0]       r_grp_ch;
    logic [7:0][7:0][7:0] r_acc;

    logic                 w_accept;
    logic                 w_is_y;
    logic                 w_is_chroma;
    logic                 w_mismatch;
    logic [1:0]           w_q;
    logic [3:0][3:0][7:0] w_avg;
    logic [7:0][7:0][7:0] w_merged;

    // No skid buffer: a new block can only land when the output slot is free
    // or is being drained in this very cycle.
    assign ready_in    = !r_valid || ready_out;
    assign w_accept    = valid_in && ready_in;
    assign w_is_y      = (ch_in == CHW'(0));
    assign w_is_chroma = (ch_in == CHW'(1)) || (ch_in == CHW'(2));

    // A chroma block whose channel differs from the open group restarts the
    // group: it becomes quadrant 0 and the earlier partial tiles are abandoned.
    assign w_mismatch  = (r_quad != 2'd0) && (ch_in != r_grp_ch);
    assign w_q         = w_mismatch ? 2'd0 : r_quad;

    function automatic logic signed [9:0] sx10(input logic [7:0] v);
        return {{2{v[7]}}, v};
    endfunction

    // 2x2 averages. The sum of four s8 values fits in 10 bits; the arithmetic
    // shift by two is taking bits [9:2], which always fits back into s8.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_avg_row
            for (genvar gj = 0; gj < 4; gj++) begin : g_avg_col
                logic signed [9:0] w_sum;
                logic signed [9:0] w_rnd;
                assign w_sum = sx10(block_in[2*gi][2*gj])   + sx10(block_in[2*gi][2*gj+1])
                             + sx10(block_in[2*gi+1][2*gj]) + sx10(block_in[2*gi+1][2*gj+1]);
                assign w_rnd = w_sum + (ROUND ? 10'sd2 : 10'sd0);
                assign w_avg[gi][gj] = w_rnd[9:2];
            end
        end
    endgenerate

    // Accumulator contents with the current quadrant's tile dropped in. This
    // is both the next accumulator value and, on the last quadrant, the output.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mrg_row
            for (genvar gj = 0; gj < 8; gj++) begin : g_mrg_col
                localparam bit LOWER = (gi >= 4);
                localparam bit RIGHT = (gj >= 4);
                assign w_merged[gi][gj] = (LOWER == w_q[1] && RIGHT == w_q[0])
                                        ? w_avg[gi % 4][gj % 4] : r_acc[gi][gj];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_block  <= '0;
            r_quad   <= 2'd0;
            r_err    <= 1'b0;
            r_grp_ch <= '0;
            r_acc    <= '0;
        end else begin
            r_err <= 1'b0;
            if (r_valid && ready_out) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_is_y) begin
                    r_block <= block_in;
                    r_ch    <= '0;
                    r_valid <= 1'b1;
                end else if (w_is_chroma) begin
                    r_acc <= w_merged;
                    r_err <= w_mismatch;
                    if (w_q == 2'd0) begin
                        r_grp_ch <= ch_in;
                    end
                    if (w_q == 2'd3) begin
                        r_block <= w_merged;
                        r_ch    <= r_grp_ch;
                        r_valid <= 1'b1;
                        r_quad  <= 2'd0;
                    end else begin
                        r_quad  <= w_q + 2'd1;
                    end
                end else begin
                    // Invalid tag: swallow the block, flag it, keep the group.
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign valid_out = r_valid;
    assign ch_out    = r_ch;
    assign block_out = r_block;
    assign quad_cnt  = r_quad;
    assign err       = r_err;

endmodule

// File: tb/tb_subsample_420_8x8.sv
module tb_subsample_420_8x8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valid_in = 1'b0;
    logic                 ready_out = 1'b1;
    logic [1:0]           ch_in = 2'd0;
    logic [7:0][7:0][7:0] block_in = '0;

    logic                 ready_in, valid_out, err;
    logic [1:0]           ch_out, quad_cnt;
    logic [7:0][7:0][7:0] block_out;

    logic                 ready_in_r0, valid_out_r0, err_r0;
    logic [1:0]           ch_out_r0, quad_cnt_r0;
    logic [7:0][7:0][7:0] block_out_r0;

    always #5 clk = ~clk;

    subsample_420_8x8 #(.CHW(2), .ROUND(1'b1)) u_dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .ch_in(ch_in), .block_in(block_in), .valid_out(valid_out),
        .ready_out(ready_out), .ch_out(ch_out), .block_out(block_out),
        .quad_cnt(quad_cnt), .err(err)
    );

    // Truncating variant, used only for the rounding comparison.
    subsample_420_8x8 #(.CHW(2), .ROUND(1'b0)) u_dut_r0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in_r0),
        .ch_in(ch_in), .block_in(block_in), .valid_out(valid_out_r0),
        .ready_out(ready_out), .ch_out(ch_out_r0), .block_out(block_out_r0),
        .quad_cnt(quad_cnt_r0), .err(err_r0)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (ROUND=1 instance) ----------------
    // State after the next rising edge is computed on each falling edge from
    // the inputs that will be sampled at that edge.
    bit m_valid = 1'b0;
    int m_ch    = 0;
    int m_blk [8][8];
    int m_acc [8][8];
    int m_q     = 0;
    int m_grp   = 0;
    bit m_err   = 1'b0;
    int dut_outs [4];

    function automatic int floor_div4(input int s);
        int q;
        q = s / 4;
        if (s < 0 && (s % 4) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int pix(input int r, input int c);
        return int'($signed(block_in[r][c]));
    endfunction

    task automatic model_step();
        int  ch;
        bit  rdy;
        if (rst) begin
            m_valid = 0; m_ch = 0; m_q = 0; m_grp = 0; m_err = 0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    m_blk[r][c] = 0; m_acc[r][c] = 0;
                end
            return;
        end
        rdy   = !m_valid || ready_out;
        m_err = 0;
        if (m_valid && ready_out) m_valid = 0;
        if (!(valid_in && rdy)) return;
        ch = int'(ch_in);
        if (ch == 0) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) m_blk[r][c] = pix(r, c);
            m_ch = 0; m_valid = 1;
        end else if (ch == 1 || ch == 2) begin
            if (m_q != 0 && ch != m_grp) begin
                m_err = 1; m_q = 0;
            end
            if (m_q == 0) m_grp = ch;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    m_acc[4*(m_q/2)+i][4*(m_q%2)+j] = floor_div4(
                        pix(2*i, 2*j) + pix(2*i, 2*j+1) + pix(2*i+1, 2*j) + pix(2*i+1, 2*j+1) + 2);
            if (m_q == 3) begin
                m_blk = m_acc; m_ch = m_grp; m_valid = 1; m_q = 0;
            end else begin
                m_q = m_q + 1;
            end
        end else begin
            m_err = 1;
        end
    endtask

    always @(negedge clk) begin
        check("valid_out", valid_out, int'(m_valid));
        check("quad_cnt", quad_cnt, m_q);
        check("err", err, int'(m_err));
        check("ready_in", ready_in, int'(!m_valid || ready_out));
        if (m_valid) begin
            int bad;
            check("ch_out", ch_out, m_ch);
            bad = -1;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (bad < 0 && int'($signed(block_out[r][c])) != m_blk[r][c]) bad = r * 8 + c;
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("[TB] FAIL block_out[%0d][%0d]: got %0d expected %0d at %0t", bad / 8, bad % 8,
                         $signed(block_out[bad/8][bad%8]), m_blk[bad/8][bad%8], $time);
            end
        end
        if (valid_out === 1'b1 && ready_out) dut_outs[ch_out]++;
        model_step();
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0][7:0][7:0] cblk(input int v);
        logic [7:0][7:0][7:0] b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = 8'(v);
        return b;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [7:0][7:0][7:0] b);
        bit got;
        int n;
        got = 0; n = 0;
        ch_in = 2'(ch); block_in = b; valid_in = 1'b1;
        do begin
            @(negedge clk);
            got = ready_in;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 50);
        if (!got) check("send_timeout", 0, 1);
        valid_in = 1'b0;
        $display("[TB] sent ch=%0d after %0d cycle(s)", ch, n);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0][7:0][7:0] b;
        logic [7:0][7:0][7:0] snap;
        int base;

        // Reset state
        idle(2);
        check("rst_valid_out", valid_out, 0);
        check("rst_block_out", block_out[3][3], 0);
        check("rst_quad_cnt", quad_cnt, 0);
        rst = 1'b0;
        idle(1);

        // T1: Y ramp passes through unchanged, one cycle after accept
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) b[r][c] = 8'(r * 8 + c);
        send(0, b);
        check("t1_valid", valid_out, 1);
        check("t1_ch", ch_out, 0);
        check("t1_px25", block_out[2][5], 21);
        check("t1_px77", block_out[7][7], 63);
        idle(1);

        // T2: four constant Cb quadrants -> one packed block
        send(1, cblk(10)); send(1, cblk(20)); send(1, cblk(-30)); send(1, cblk(127));
        check("t2_ch", ch_out, 1);
        check("t2_tl", $signed(block_out[0][0]), 10);
        check("t2_tr", $signed(block_out[2][7]), 20);
        check("t2_bl", $signed(block_out[5][1]), -30);
        check("t2_br", $signed(block_out[7][7]), 127);
        idle(1);

        // T3: rounding. {1,1,2,2}: sum 6 -> 2 rounded / 1 truncated.
        // {-1,-1,-1,-2}: sum -5 -> -1 / -2. {1,1,1,2}: sum 5 -> 1 either way.
        b = cblk(0);
        b[0][0] = 8'd1; b[0][1] = 8'd1; b[1][0] = 8'd2; b[1][1] = 8'd2;
        b[0][2] = 8'hFF; b[0][3] = 8'hFF; b[1][2] = 8'hFF; b[1][3] = 8'hFE;
        b[0][4] = 8'd1; b[0][5] = 8'd1; b[1][4] = 8'd1; b[1][5] = 8'd2;
        send(1, b); send(1, cblk(0)); send(1, cblk(0)); send(1, cblk(0));
        check("t3_r1_a", $signed(block_out[0][0]), 2);
        check("t3_r1_b", $signed(block_out[0][1]), -1);
        check("t3_r1_c", $signed(block_out[0][2]), 1);
        check("t3_r0_a", $signed(block_out_r0[0][0]), 1);
        check("t3_r0_b", $signed(block_out_r0[0][1]), -2);
        check("t3_r0_c", $signed(block_out_r0[0][2]), 1);
        idle(1);

        // Invalid tag inside a group: flagged, group position kept
        send(1, cblk(5));
        send(3, cblk(77));
        check("inv_err", err, 1);
        check("inv_quad", quad_cnt, 1);
        send(1, cblk(6)); send(1, cblk(7)); send(1, cblk(8));
        check("inv_done_ch", ch_out, 1);
        check("inv_done_px", $signed(block_out[7][7]), 8);
        idle(1);

        // T4: Cr breaks an open Cb group
        base = dut_outs[1];
        send(1, cblk(11)); send(1, cblk(12));
        send(2, cblk(21));
        check("t4_err", err, 1);
        check("t4_quad", quad_cnt, 1);
        idle(1);
        check("t4_err_pulse", err, 0);
        send(2, cblk(22)); send(2, cblk(23)); send(2, cblk(24));
        check("t4_ch", ch_out, 2);
        check("t4_tl", $signed(block_out[0][0]), 21);
        check("t4_br", $signed(block_out[7][7]), 24);
        idle(1);
        check("t4_no_cb_out", dut_outs[1], base);

        // T5: back-pressure holds the output; release accepts the queued Y
        send(0, cblk(7));
        ready_out = 1'b0;
        snap = block_out;
        ch_in = 2'd0; block_in = cblk(99); valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle(1);
            check("t5_ready_in", ready_in, 0);
            check("t5_stable", int'(block_out === snap), 1);
        end
        ready_out = 1'b1;
        #1;
        check("t5_release_ready", ready_in, 1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("t5_new_valid", valid_out, 1);
        check("t5_new_px", block_out[4][4], 99);
        idle(1);

        // T6: reset mid-group discards the partial Cb group
        send(1, cblk(40)); send(1, cblk(41));
        rst = 1'b1;
        idle(1);
        check("t6_rst_valid", valid_out, 0);
        check("t6_rst_quad", quad_cnt, 0);
        check("t6_rst_block", block_out[0][0], 0);
        idle(1);
        rst = 1'b0;
        base = dut_outs[2];
        send(2, cblk(1)); send(2, cblk(2)); send(2, cblk(3)); send(2, cblk(4));
        check("t6_ch", ch_out, 2);
        check("t6_tl", $signed(block_out[0][0]), 1);
        check("t6_tr", $signed(block_out[0][7]), 2);
        check("t6_bl", $signed(block_out[7][0]), 3);
        check("t6_br", $signed(block_out[7][7]), 4);
        idle(2);
        check("t6_one_cr_out", dut_outs[2], base + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
